// File: rtl/emu_bus_bridge.sv
// Host-to-emulated-DUT bridge: synchronises host controls, sequences the DUT
// reset from PLL lock, debounces the enable switch and queues DUT results.
module emu_bus_bridge #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int RST_HOLD    = 16,
  parameter int DBNC_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pll_lock_i,
  input  logic                          ena_sw_i,
  input  logic [DATA_W-1:0]             data_i,
  input  logic                          data_v_i,
  input  logic                          data_mode_i,
  input  logic                          data_rst_addr_i,
  input  logic                          res_ack_i,
  input  logic [DATA_W-1:0]             dut_res_i,
  input  logic                          dut_res_v_i,
  output logic [DATA_W-1:0]             dut_data_o,
  output logic                          dut_data_v_o,
  output logic                          dut_mode_o,
  output logic                          dut_rst_addr_o,
  output logic                          dut_rst_n_o,
  output logic                          dut_ena_o,
  output logic [DATA_W-1:0]             res_o,
  output logic                          res_v_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overflow_o
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam int DBNC_W = $clog2(DBNC_CYCLES + 1);
  localparam int BUS_W  = DATA_W + 5;

  typedef enum logic [1:0] {RST, WAIT_LOCK, HOLD, RUN} state_t;

  // All host-side levels share one synchroniser chain so they stay aligned.
  logic [SYNC_STAGES-1:0][BUS_W-1:0] sync_reg;
  logic [BUS_W-1:0]  sync_in;
  logic [1:0]        ena_sync_reg;
  logic              lock_s, ack_s, rst_addr_s, mode_s, data_v_s, ena_s;
  logic [DATA_W-1:0] data_s;

  assign sync_in = {pll_lock_i, res_ack_i, data_rst_addr_i, data_mode_i, data_v_i, data_i};
  assign {lock_s, ack_s, rst_addr_s, mode_s, data_v_s, data_s} = sync_reg[SYNC_STAGES-1];
  assign ena_s = ena_sync_reg[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg     <= '0;
      ena_sync_reg <= '0;
    end else begin
      sync_reg     <= {sync_reg[SYNC_STAGES-2:0], sync_in};
      ena_sync_reg <= {ena_sync_reg[0], ena_sw_i};
    end
  end

  state_t             state_reg, state_next;
  logic [HOLD_W-1:0]  hold_cnt_reg;
  logic               run_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= RST;
      hold_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == WAIT_LOCK)
        hold_cnt_reg <= HOLD_W'(RST_HOLD - 1);
      else if (state_reg == HOLD && hold_cnt_reg != '0)
        hold_cnt_reg <= hold_cnt_reg - HOLD_W'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RST:       state_next = WAIT_LOCK;
      WAIT_LOCK: if (lock_s) state_next = HOLD;
      HOLD:      if (!lock_s) state_next = WAIT_LOCK;
                 else if (hold_cnt_reg == '0) state_next = RUN;
      RUN:       if (!lock_s) state_next = WAIT_LOCK;
      default:   state_next = RST;
    endcase
  end

  // Everything gated by RUN keys off the next state, so outputs and flush
  // change on the same edge as the state itself.
  always_comb begin
    run_next = (state_next == RUN);
  end

  logic data_v_prev_reg, ack_prev_reg, data_rise;
  assign data_rise = data_v_s & ~data_v_prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_v_prev_reg <= 1'b0;
      ack_prev_reg    <= 1'b0;
      dut_rst_n_o     <= 1'b0;
      dut_data_v_o    <= 1'b0;
      dut_data_o      <= '0;
      dut_mode_o      <= 1'b0;
      dut_rst_addr_o  <= 1'b0;
    end else begin
      data_v_prev_reg <= data_v_s;
      ack_prev_reg    <= ack_s;
      dut_rst_n_o     <= run_next;
      dut_data_v_o    <= run_next & data_rise;
      if (run_next & data_rise)
        dut_data_o <= data_s;
      dut_mode_o      <= mode_s;
      dut_rst_addr_o  <= rst_addr_s;
    end
  end

  logic [DBNC_W-1:0] dbnc_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbnc_cnt_reg <= '0;
      dut_ena_o    <= 1'b0;
    end else if (ena_s == dut_ena_o) begin
      dbnc_cnt_reg <= '0;
    end else if (dbnc_cnt_reg == DBNC_W'(DBNC_CYCLES - 1)) begin
      dbnc_cnt_reg <= '0;
      dut_ena_o    <= ena_s;
    end else begin
      dbnc_cnt_reg <= dbnc_cnt_reg + DBNC_W'(1);
    end
  end

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic              in_run, full, push_req, pop, wr_en;

  assign in_run   = (state_reg == RUN);
  assign full     = (level_o == LVL_W'(FIFO_DEPTH));
  assign push_req = in_run & dut_res_v_i;
  assign pop      = in_run & ack_s & ~ack_prev_reg & res_v_o;
  assign wr_en    = push_req & (~full | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_o    <= '0;
      overflow_o <= 1'b0;
    end else if (!run_next) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_o    <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)   rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (wr_en & ~pop)      level_o <= level_o + LVL_W'(1);
      else if (pop & ~wr_en) level_o <= level_o - LVL_W'(1);
      if (push_req & full & ~pop) overflow_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= dut_res_i;
  end

  // Head is read combinationally so a push into an empty FIFO shows next cycle.
  assign res_v_o = (level_o != '0);
  assign res_o   = res_v_o ? mem[rd_ptr_reg] : '0;

endmodule

// File: tb/tb_emu_bus_bridge.sv
// Randomised bench for emu_bus_bridge with a queue-based result FIFO model.
module tb_emu_bus_bridge;
  localparam int S     = 2;
  localparam int DEPTH = 8;
  localparam int HOLDC = 16;
  localparam int DBNC  = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock_i = 1'b0, ena_sw_i = 1'b0;
  logic [7:0] data_i = '0;
  logic       data_v_i = 1'b0, data_mode_i = 1'b0, data_rst_addr_i = 1'b0;
  logic       res_ack_i = 1'b0;
  logic [7:0] dut_res_i = '0;
  logic       dut_res_v_i = 1'b0;
  logic [7:0] dut_data_o, res_o;
  logic       dut_data_v_o, dut_mode_o, dut_rst_addr_o, dut_rst_n_o, dut_ena_o;
  logic       res_v_o, overflow_o;
  logic [3:0] level_o;

  emu_bus_bridge dut (
    .clk(clk), .rst_n(rst_n), .pll_lock_i(pll_lock_i), .ena_sw_i(ena_sw_i),
    .data_i(data_i), .data_v_i(data_v_i), .data_mode_i(data_mode_i),
    .data_rst_addr_i(data_rst_addr_i), .res_ack_i(res_ack_i),
    .dut_res_i(dut_res_i), .dut_res_v_i(dut_res_v_i),
    .dut_data_o(dut_data_o), .dut_data_v_o(dut_data_v_o), .dut_mode_o(dut_mode_o),
    .dut_rst_addr_o(dut_rst_addr_o), .dut_rst_n_o(dut_rst_n_o), .dut_ena_o(dut_ena_o),
    .res_o(res_o), .res_v_o(res_v_o), .level_o(level_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] model_q[$];
  logic       model_ovf = 1'b0;
  logic [7:0] exp_head;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus helpers: each applies one FIFO operation and updates the model.
  task automatic push_one(input logic [7:0] val);
    dut_res_i = val;
    dut_res_v_i = 1'b1;
    tick();
    dut_res_v_i = 1'b0;
    if (model_q.size() < DEPTH) model_q.push_back(val);
    else model_ovf = 1'b1;
  endtask

  task automatic ack_one();
    res_ack_i = 1'b1;
    repeat (S + 1) tick();
    if (model_q.size() > 0) void'(model_q.pop_front());
    res_ack_i = 1'b0;
    repeat (S) tick();
  endtask

  task automatic push_pop(input logic [7:0] val);
    res_ack_i = 1'b1;
    repeat (S) tick();
    dut_res_i = val;
    dut_res_v_i = 1'b1;
    tick();
    dut_res_v_i = 1'b0;
    if (model_q.size() > 0) void'(model_q.pop_front());
    model_q.push_back(val);
    res_ack_i = 1'b0;
    repeat (S) tick();
  endtask

  task automatic go_run();
    int n;
    pll_lock_i = 1'b1;
    n = 0;
    while (!dut_rst_n_o && n < 200) begin
      tick();
      n++;
    end
    if (!dut_rst_n_o) begin
      tests++;
      fails++;
      $display("FAIL go_run: dut_rst_n_o=%b after %0d cycles, required 1", dut_rst_n_o, n);
    end
  endtask

  task automatic flush_run();
    pll_lock_i = 1'b0;
    repeat (S + 2) tick();
    model_q.delete();
    model_ovf = 1'b0;
    go_run();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    tests++;
    if ({dut_rst_n_o, dut_ena_o, dut_data_v_o, dut_mode_o, dut_rst_addr_o} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: rst_n/ena/dv/mode/ra=%b required 00000",
               {dut_rst_n_o, dut_ena_o, dut_data_v_o, dut_mode_o, dut_rst_addr_o});
    end
    tests++;
    if (dut_data_o !== 8'h00 || res_o !== 8'h00) begin
      fails++;
      $display("FAIL reset_data: data_o=%h res_o=%h required 00 00", dut_data_o, res_o);
    end
    tests++;
    if (level_o !== 4'd0 || res_v_o !== 1'b0 || overflow_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_fifo: level=%0d res_v=%b ovf=%b required 0 0 0", level_o, res_v_o, overflow_o);
    end
  endtask

  // Lock already high at release: HOLD entered S+1 edges later, RUN RST_HOLD later.
  task automatic test_sequencer();
    pll_lock_i = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (S + HOLDC) tick();
    tests++;
    if (dut_rst_n_o !== 1'b0) begin
      fails++;
      $display("FAIL seq_early: dut_rst_n_o=%b one cycle before release, required 0", dut_rst_n_o);
    end
    tick();
    tests++;
    if (dut_rst_n_o !== 1'b1) begin
      fails++;
      $display("FAIL seq_release: dut_rst_n_o=%b at RST_HOLD after HOLD, required 1", dut_rst_n_o);
    end
  endtask

  task automatic test_lock_drop();
    for (int i = 0; i < 3; i++) push_one(8'($urandom));
    pll_lock_i = 1'b0;
    repeat (S + 1) tick();
    model_q.delete();
    model_ovf = 1'b0;
    tests++;
    if (dut_rst_n_o !== 1'b0 || level_o !== 4'd0) begin
      fails++;
      $display("FAIL lock_drop: dut_rst_n_o=%b level=%0d required 0 0", dut_rst_n_o, level_o);
    end
    go_run();
  endtask

  task automatic test_data_strobe();
    logic [7:0] val;
    logic       mode, ra, prev_mode, prev_ra;
    int         pulses, pulse_t;
    logic [7:0] pulse_data;
    prev_mode = 1'b0;
    prev_ra = 1'b0;
    for (int it = 0; it < 5; it++) begin
      val  = (it == 0) ? 8'hA5 : 8'($urandom);
      mode = 1'($urandom);
      ra   = 1'($urandom);
      data_i = val;
      data_mode_i = mode;
      data_rst_addr_i = ra;
      data_v_i = 1'b1;
      pulses = 0;
      pulse_t = -1;
      pulse_data = '0;
      for (int t = 1; t <= 10; t++) begin
        tick();
        if (t == S) begin
          tests++;
          if (dut_mode_o !== prev_mode || dut_rst_addr_o !== prev_ra) begin
            fails++;
            $display("FAIL level_early it=%0d: mode=%b ra=%b required %b %b", it, dut_mode_o, dut_rst_addr_o, prev_mode, prev_ra);
          end
        end
        if (t == S + 1) begin
          tests++;
          if (dut_mode_o !== mode || dut_rst_addr_o !== ra) begin
            fails++;
            $display("FAIL level_sync it=%0d: mode=%b ra=%b required %b %b", it, dut_mode_o, dut_rst_addr_o, mode, ra);
          end
        end
        if (dut_data_v_o === 1'b1) begin
          pulses++;
          pulse_t = t;
          pulse_data = dut_data_o;
        end
        if (t == 5) begin
          data_v_i = 1'b0;
          data_i = ~val;
        end
      end
      tests++;
      if (pulses != 1 || pulse_t != S + 1 || pulse_data !== val) begin
        fails++;
        $display("FAIL strobe it=%0d: pulses=%0d at t=%0d data=%h required 1 at t=%0d data=%h",
                 it, pulses, pulse_t, pulse_data, S + 1, val);
      end
      tests++;
      if (dut_data_o !== val) begin
        fails++;
        $display("FAIL data_hold it=%0d: dut_data_o=%h required %h", it, dut_data_o, val);
      end
      prev_mode = mode;
      prev_ra = ra;
    end
  endtask

  task automatic test_fifo_random();
    flush_run();
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0, 1: push_one(8'($urandom));
        2:    ack_one();
        default: push_pop(8'($urandom));
      endcase
      exp_head = (model_q.size() > 0) ? model_q[0] : 8'h00;
      tests++;
      if (level_o !== 4'(model_q.size()) || res_v_o !== (model_q.size() > 0) ||
          res_o !== exp_head || overflow_o !== model_ovf) begin
        fails++;
        $display("FAIL fifo_rand op=%0d: level=%0d v=%b head=%h ovf=%b required %0d %b %h %b",
                 i, level_o, res_v_o, res_o, overflow_o, model_q.size(), model_q.size() > 0, exp_head, model_ovf);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] pushed[9];
    flush_run();
    for (int i = 0; i < 9; i++) begin
      pushed[i] = 8'($urandom);
      push_one(pushed[i]);
    end
    tests++;
    if (level_o !== 4'd8 || overflow_o !== 1'b1) begin
      fails++;
      $display("FAIL overflow: level=%0d ovf=%b required 8 1", level_o, overflow_o);
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (res_v_o !== 1'b1 || res_o !== pushed[i]) begin
        fails++;
        $display("FAIL ovf_read idx=%0d: v=%b head=%h required 1 %h", i, res_v_o, res_o, pushed[i]);
      end
      ack_one();
    end
    ack_one();
    tests++;
    if (level_o !== 4'd0 || res_v_o !== 1'b0 || overflow_o !== 1'b1) begin
      fails++;
      $display("FAIL ovf_drain: level=%0d v=%b ovf=%b required 0 0 1", level_o, res_v_o, overflow_o);
    end
  endtask

  task automatic test_full_push_pop();
    flush_run();
    for (int i = 0; i < DEPTH; i++) push_one(8'($urandom));
    for (int i = 0; i < 5; i++) begin
      push_pop(8'($urandom));
      tests++;
      if (level_o !== 4'd8 || overflow_o !== 1'b0) begin
        fails++;
        $display("FAIL full_pp idx=%0d: level=%0d ovf=%b required 8 0", i, level_o, overflow_o);
      end
    end
    while (model_q.size() > 0) begin
      tests++;
      if (res_o !== model_q[0] || level_o !== 4'(model_q.size())) begin
        fails++;
        $display("FAIL wrap_order: head=%h level=%0d required %h %0d", res_o, level_o, model_q[0], model_q.size());
      end
      ack_one();
    end
  endtask

  task automatic test_debounce();
    int early_ones;
    early_ones = 0;
    for (int k = 0; k < 6; k++) begin
      ena_sw_i = ~ena_sw_i;
      repeat (100) begin
        tick();
        if (dut_ena_o !== 1'b0) early_ones++;
      end
    end
    ena_sw_i = 1'b1;
    repeat (2 + DBNC - 1) begin
      tick();
      if (dut_ena_o !== 1'b0) early_ones++;
    end
    tests++;
    if (early_ones != 0) begin
      fails++;
      $display("FAIL dbnc_early: dut_ena_o high in %0d cycles, required 0", early_ones);
    end
    tick();
    tests++;
    if (dut_ena_o !== 1'b1) begin
      fails++;
      $display("FAIL dbnc_set: dut_ena_o=%b after %0d stable cycles, required 1", dut_ena_o, DBNC);
    end
  endtask

  task automatic test_async_reset();
    flush_run();
    for (int i = 0; i < 3; i++) push_one(8'($urandom));
    dut_res_i = 8'h5A;
    dut_res_v_i = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if ({dut_rst_n_o, dut_ena_o, dut_data_v_o, res_v_o, overflow_o} !== 5'b0 ||
        level_o !== 4'd0 || res_o !== 8'h00 || dut_data_o !== 8'h00) begin
      fails++;
      $display("FAIL async_rst: rst/ena/dv/v/ovf=%b level=%0d res=%h data=%h required 00000 0 00 00",
               {dut_rst_n_o, dut_ena_o, dut_data_v_o, res_v_o, overflow_o}, level_o, res_o, dut_data_o);
    end
    dut_res_v_i = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (S + HOLDC) tick();
    tests++;
    if (dut_rst_n_o !== 1'b0) begin
      fails++;
      $display("FAIL reseq_early: dut_rst_n_o=%b required 0", dut_rst_n_o);
    end
    tick();
    tests++;
    if (dut_rst_n_o !== 1'b1 || level_o !== 4'd0 || res_v_o !== 1'b0) begin
      fails++;
      $display("FAIL reseq: dut_rst_n_o=%b level=%0d v=%b required 1 0 0", dut_rst_n_o, level_o, res_v_o);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequencer();
    test_data_strobe();
    test_lock_drop();
    test_fifo_random();
    test_overflow();
    test_full_push_pop();
    test_debounce();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/emu_bus_bridge.md
EMU_BUS_BRIDGE -- requirements
Module: emu_bus_bridge

Interface
REQ-001 Parameters (name, default, meaning): DATA_W, 8, host/DUT data width; SYNC_STAGES, 2, synchroniser depth (>=2); FIFO_DEPTH, 8, result FIFO entries (power of 2, >=2); RST_HOLD, 16, DUT reset hold cycles after lock; DBNC_CYCLES, 1024, enable debounce stability cycles.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- pll_lock_i, in, 1, PLL locked.
- ena_sw_i, in, 1, raw enable switch.
- data_i, in, DATA_W, host data.
- data_v_i, in, 1, host data valid level.
- data_mode_i, in, 1, host mode.
- data_rst_addr_i, in, 1, host address reset.
- res_ack_i, in, 1, host result acknowledge level.
- dut_res_i, in, DATA_W, DUT result.
- dut_res_v_i, in, 1, DUT result valid pulse.
- dut_data_o, out, DATA_W, data to DUT.
- dut_data_v_o, out, 1, one-cycle data strobe.
- dut_mode_o, out, 1, synchronised mode.
- dut_rst_addr_o, out, 1, synchronised address reset.
- dut_rst_n_o, out, 1, DUT reset, active-low.
- dut_ena_o, out, 1, debounced enable.
- res_o, out, DATA_W, FIFO head.
- res_v_o, out, 1, FIFO non-empty.
- level_o, out, $clog2(FIFO_DEPTH)+1, FIFO occupancy.
- overflow_o, out, 1, sticky overflow flag.

Function
REQ-003 data_i, data_v_i, data_mode_i, data_rst_addr_i, res_ack_i and pll_lock_i shall each pass through a SYNC_STAGES flop chain before use; ena_sw_i shall pass through a 2-stage chain.
REQ-004 dut_data_v_o shall pulse high for exactly one cycle on each rising edge of synchronised data_v. dut_data_o shall take the synchronised data_i value in that same cycle and hold it until the next strobe.
REQ-005 Latency from a data_v_i rise to dut_data_v_o shall be SYNC_STAGES+1 cycles.
REQ-006 dut_mode_o and dut_rst_addr_o shall be the registered synchronised levels, with the same SYNC_STAGES+1 latency.
REQ-007 The reset sequencer FSM shall have states RST, WAIT_LOCK, HOLD and RUN.
- RST -> WAIT_LOCK unconditionally.
- WAIT_LOCK -> HOLD when synchronised lock is 1; the hold counter loads RST_HOLD-1.
- HOLD counts down and goes to RUN when the count is 0 and lock is still 1.
- HOLD -> WAIT_LOCK if lock drops.
- RUN -> WAIT_LOCK if lock drops.
REQ-008 dut_rst_n_o shall be registered and equal 1 only in RUN. It shall rise exactly RST_HOLD cycles after the FSM enters HOLD.
REQ-009 Outside RUN, the FIFO shall be flushed (level 0), dut_data_v_o forced 0 and dut_res_v_i ignored; overflow_o shall be cleared.
REQ-010 dut_ena_o shall change to the synchronised switch value only after that value has differed from dut_ena_o for DBNC_CYCLES consecutive cycles. Any bounce shall restart the count.
REQ-011 In RUN, a cycle with dut_res_v_i=1 shall push dut_res_i when the FIFO is not full.
REQ-012 A push while full with no pop in the same cycle shall drop the data and set overflow_o. overflow_o shall hold until reset or exit from RUN.
REQ-013 Pop shall occur on each rising edge of synchronised res_ack_i while the FIFO is not empty. A rising edge while empty shall be ignored and shall not be remembered.
REQ-014 A simultaneous push and pop shall leave level_o unchanged. A simultaneous push and pop while full shall succeed with no overflow.
REQ-015 res_v_o shall be 1 exactly when level_o>0, and res_o shall show the head entry. An entry pushed into an empty FIFO shall be visible the next cycle.
REQ-016 Read and write pointers shall wrap modulo FIFO_DEPTH. level_o shall never exceed FIFO_DEPTH.

Reset
REQ-017 rst_n low shall asynchronously force the following:
- FSM to RST; all synchronisers to 0.
- dut_rst_n_o=0, dut_ena_o=0, dut_data_v_o=0, dut_data_o=0, dut_mode_o=0, dut_rst_addr_o=0.
- res_v_o=0, res_o=0, level_o=0, overflow_o=0.
- Counters to 0.
REQ-018 rst_n deassertion during any activity shall restart the sequence from RST; no FIFO content shall survive.

Verification
REQ-019 Lock held at 1 from reset release: dut_rst_n_o rises RST_HOLD cycles after HOLD entry (defaults: 16). Drop lock in RUN: dut_rst_n_o=0 within SYNC_STAGES+1 cycles and level_o=0.
REQ-020 Hold data_v_i high for 5 cycles with data_i=8'hA5: exactly one dut_data_v_o pulse with dut_data_o=8'hA5, SYNC_STAGES+1 cycles after the rise.
REQ-021 Push 9 results into the 8-deep FIFO with no acks: level_o=8, overflow_o=1, and the 9th value is absent on readout.
REQ-022 FIFO full, then push and ack-rise in the same cycle: level_o stays 8, overflow_o stays 0, and FIFO order is preserved across pointer wrap.
REQ-023 ena_sw_i toggles every 100 cycles, then stays at 1: dut_ena_o stays 0 until 1024 stable cycles, then becomes 1.
REQ-024 Assert rst_n low mid-push with level_o=3: all outputs return to their reset values immediately, and after release the FSM re-sequences from RST.
